// File: rtl/sec_buffer_arbiter.sv
// Range buffer with a two-requester round-robin write arbiter, a sequential
// flush engine and a one-cycle range lookup that can latch a sticky crash flag.
module sec_buffer_arbiter #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned AW    = 32
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic [1:0]                   req_valid_i,
  input  logic [2*AW-1:0]              req_base_i,
  input  logic [2*AW-1:0]              req_limit_i,
  output logic [1:0]                   req_ready_o,
  input  logic                         flush_i,
  input  logic                         lookup_valid_i,
  input  logic [AW-1:0]                lookup_addr_i,
  output logic                         lookup_valid_o,
  output logic                         lookup_hit_o,
  input  logic                         en_crash_i,
  output logic                         crash_o,
  output logic [$clog2(DEPTH):0]       count_o,
  output logic                         busy_o
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_FLUSH = 1'b1
  } state_e;

  state_e            state_q, state_d;
  logic [PW-1:0]     flush_idx_q, flush_idx_d;
  logic [PW-1:0]     wr_ptr_q;
  logic [CW-1:0]     count_q;
  logic              rr_favor_q;

  logic [DEPTH-1:0]  ent_valid_q;
  logic [AW-1:0]     ent_base_q  [DEPTH];
  logic [AW-1:0]     ent_limit_q [DEPTH];

  logic [1:0]        grant_c;
  logic              flush_accept_c;
  logic              hs_any_c;
  logic              wr_en_c;
  logic [AW-1:0]     wr_base_c;
  logic [AW-1:0]     wr_limit_c;
  logic              range_hit_c;
  logic              lookup_hit_c;

  // Next-state, grant and flush sequencing
  always_comb begin
    state_d        = state_q;
    flush_idx_d    = flush_idx_q;
    grant_c        = 2'b00;
    flush_accept_c = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (flush_i) begin
          flush_accept_c = 1'b1;
          state_d        = ST_FLUSH;
          flush_idx_d    = '0;
        end else if (req_valid_i == 2'b11) begin
          grant_c = rr_favor_q ? 2'b10 : 2'b01;
        end else begin
          grant_c = req_valid_i;
        end
      end
      ST_FLUSH: begin
        flush_idx_d = flush_idx_q + PW'(1);
        if (flush_idx_q == PW'(DEPTH - 1)) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign req_ready_o = grant_c;
  assign hs_any_c    = |(req_valid_i & grant_c);
  assign wr_base_c   = grant_c[1] ? req_base_i[AW +: AW]  : req_base_i[0 +: AW];
  assign wr_limit_c  = grant_c[1] ? req_limit_i[AW +: AW] : req_limit_i[0 +: AW];
  assign wr_en_c     = hs_any_c && (wr_base_c <= wr_limit_c);

  // Inclusive range match against entries as they stand this cycle
  always_comb begin
    range_hit_c = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (ent_valid_q[i] && (ent_base_q[i] <= lookup_addr_i) &&
          (lookup_addr_i <= ent_limit_q[i])) begin
        range_hit_c = 1'b1;
      end
    end
  end

  assign lookup_hit_c = lookup_valid_i && (state_q == ST_IDLE) && !flush_i && range_hit_c;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q        <= ST_IDLE;
      flush_idx_q    <= '0;
      wr_ptr_q       <= '0;
      count_q        <= '0;
      rr_favor_q     <= 1'b0;
      lookup_valid_o <= 1'b0;
      lookup_hit_o   <= 1'b0;
      crash_o        <= 1'b0;
      busy_o         <= 1'b0;
    end else begin
      state_q        <= state_d;
      flush_idx_q    <= flush_idx_d;
      busy_o         <= (state_d == ST_FLUSH);
      lookup_valid_o <= lookup_valid_i;
      lookup_hit_o   <= lookup_hit_c;
      if (flush_accept_c) begin
        crash_o <= 1'b0;
      end else if (lookup_hit_c && en_crash_i) begin
        crash_o <= 1'b1;
      end
      if (flush_accept_c) begin
        wr_ptr_q <= '0;
        count_q  <= '0;
      end else if (wr_en_c) begin
        wr_ptr_q <= wr_ptr_q + PW'(1);
        if (count_q != CW'(DEPTH)) begin
          count_q <= count_q + CW'(1);
        end
      end
      // Rejected (inverted) ranges still complete the handshake and rotate priority
      if (hs_any_c) begin
        rr_favor_q <= ~grant_c[1];
      end
    end
  end

  // Valid bits: cleared one slot per cycle while flushing
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ent_valid_q <= '0;
    end else if (state_q == ST_FLUSH) begin
      ent_valid_q[flush_idx_q] <= 1'b0;
    end else if (wr_en_c) begin
      ent_valid_q[wr_ptr_q] <= 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (wr_en_c) begin
      ent_base_q[wr_ptr_q]  <= wr_base_c;
      ent_limit_q[wr_ptr_q] <= wr_limit_c;
    end
  end

  assign count_o = count_q;

endmodule

// File: tb/tb_sec_buffer_arbiter.sv
// Scoreboard bench for sec_buffer_arbiter: a behavioural model predicts each
// cycle's registered outputs, which are queued and compared after the edge.
module tb_sec_buffer_arbiter;

  localparam int unsigned DEPTH = 8;
  localparam int unsigned AW    = 32;

  logic              clk_i = 1'b0;
  logic              rst_i;
  logic [1:0]        req_valid_i;
  logic [2*AW-1:0]   req_base_i;
  logic [2*AW-1:0]   req_limit_i;
  logic [1:0]        req_ready_o;
  logic              flush_i;
  logic              lookup_valid_i;
  logic [AW-1:0]     lookup_addr_i;
  logic              lookup_valid_o;
  logic              lookup_hit_o;
  logic              en_crash_i;
  logic              crash_o;
  logic [3:0]        count_o;
  logic              busy_o;

  sec_buffer_arbiter #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .req_valid_i    (req_valid_i),
    .req_base_i     (req_base_i),
    .req_limit_i    (req_limit_i),
    .req_ready_o    (req_ready_o),
    .flush_i        (flush_i),
    .lookup_valid_i (lookup_valid_i),
    .lookup_addr_i  (lookup_addr_i),
    .lookup_valid_o (lookup_valid_o),
    .lookup_hit_o   (lookup_hit_o),
    .en_crash_i     (en_crash_i),
    .crash_o        (crash_o),
    .count_o        (count_o),
    .busy_o         (busy_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic       lv;
    logic       hit;
    logic       crash;
    logic [3:0] cnt;
    logic       busy;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  // Reference model: flush clears everything at once and counts down its length
  bit          m_v [DEPTH];
  logic [31:0] m_b [DEPTH];
  logic [31:0] m_l [DEPTH];
  int          m_ptr, m_cnt, m_fleft;
  bit          m_fav, m_crash;
  logic [1:0]  last_grant;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) m_v[i] = 1'b0;
    m_ptr = 0; m_cnt = 0; m_fleft = 0; m_fav = 1'b0; m_crash = 1'b0;
  endtask

  task automatic idle_inputs();
    rst_i = 1'b0; req_valid_i = 2'b00; req_base_i = '0; req_limit_i = '0;
    flush_i = 1'b0; lookup_valid_i = 1'b0; lookup_addr_i = '0; en_crash_i = 1'b0;
  endtask

  task automatic set_req(input int k, input logic [31:0] b, input logic [31:0] l);
    req_valid_i[k] = 1'b1;
    req_base_i[32*k +: 32]  = b;
    req_limit_i[32*k +: 32] = l;
  endtask

  task automatic set_lookup(input logic [31:0] a);
    lookup_valid_i = 1'b1;
    lookup_addr_i  = a;
  endtask

  // One clock: check the combinational grant, predict, clock, compare
  task automatic cycle();
    logic [1:0]  er;
    logic        hit;
    logic [31:0] b, l;
    int          k;
    exp_t        e, got;
    #1;
    er = 2'b00;
    if (m_fleft == 0 && !flush_i) begin
      if (req_valid_i == 2'b11) er = m_fav ? 2'b10 : 2'b01;
      else                      er = req_valid_i;
    end
    check("ready", req_ready_o, er);
    last_grant = req_ready_o;
    hit = 1'b0;
    if (lookup_valid_i && m_fleft == 0 && !flush_i)
      for (int i = 0; i < DEPTH; i++)
        if (m_v[i] && m_b[i] <= lookup_addr_i && lookup_addr_i <= m_l[i]) hit = 1'b1;
    if (rst_i) begin
      model_reset();
      e = '0;
    end else begin
      if (m_fleft > 0) begin
        m_fleft--;
      end else if (flush_i) begin
        for (int i = 0; i < DEPTH; i++) m_v[i] = 1'b0;
        m_ptr = 0; m_cnt = 0; m_fleft = DEPTH; m_crash = 1'b0;
      end else if (er != 2'b00) begin
        k = er[1] ? 1 : 0;
        b = req_base_i[32*k +: 32];
        l = req_limit_i[32*k +: 32];
        if (b <= l) begin
          m_v[m_ptr] = 1'b1; m_b[m_ptr] = b; m_l[m_ptr] = l;
          m_ptr = (m_ptr + 1) % DEPTH;
          if (m_cnt < DEPTH) m_cnt++;
        end
        m_fav = (k == 0);
      end
      if (hit && en_crash_i) m_crash = 1'b1;
      e.lv = lookup_valid_i; e.hit = hit; e.crash = m_crash;
      e.cnt = 4'(m_cnt); e.busy = (m_fleft > 0);
    end
    exp_q.push_back(e);
    @(posedge clk_i);
    #1;
    got = exp_q.pop_front();
    check("lookup_valid", lookup_valid_o, got.lv);
    check("lookup_hit", lookup_hit_o, got.hit);
    check("crash", crash_o, got.crash);
    check("count", count_o, got.cnt);
    check("busy", busy_o, got.busy);
    idle_inputs();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    int nb;
    int guard;
    logic [1:0] g [4];
    idle_inputs();
    rst_i = 1'b1;
    repeat (2) @(posedge clk_i);
    #1;
    model_reset();
    check("rst_count", count_o, 0);
    check("rst_busy", busy_o, 0);
    check("rst_crash", crash_o, 0);
    check("rst_lv", lookup_valid_o, 0);
    rst_i = 1'b0;

    // Round robin from reset: 0,1,0,1
    for (int i = 0; i < 4; i++) begin
      set_req(0, 32'h100 * i, 32'h100 * i + 32'hF);
      set_req(1, 32'h5000 + 32'h100 * i, 32'h50FF + 32'h100 * i);
      cycle();
      g[i] = last_grant;
    end
    check("rr_g0", g[0], 2'b01);
    check("rr_g1", g[1], 2'b10);
    check("rr_g2", g[2], 2'b01);
    check("rr_g3", g[3], 2'b10);
    check("rr_count", count_o, 4);

    rst_i = 1'b1; cycle();

    // DEPTH+1 writes, oldest overwritten
    for (int i = 0; i <= DEPTH; i++) begin
      set_req(0, 32'h1000 + 16 * i, 32'h100F + 16 * i);
      cycle();
    end
    check("wrap_count", count_o, 8);
    set_lookup(32'h1000); cycle();
    check("wrap_miss", lookup_hit_o, 0);
    set_lookup(32'h1080); cycle();
    check("wrap_hit", lookup_hit_o, 1);

    // Inverted range is accepted but not stored
    set_req(1, 32'h2000, 32'h1FFF); cycle();
    check("inv_ready", last_grant, 2'b10);
    check("inv_count", count_o, 8);
    set_lookup(32'h2000); cycle();
    check("inv_miss", lookup_hit_o, 0);

    // Crash latch, then flush
    set_req(0, 32'h3000, 32'h30FF); cycle();
    set_lookup(32'h30FF); en_crash_i = 1'b1; cycle();
    check("crash_hit", lookup_hit_o, 1);
    check("crash_set", crash_o, 1);
    repeat (3) cycle();
    check("crash_sticky", crash_o, 1);
    flush_i = 1'b1; cycle();
    check("flush_crash_clr", crash_o, 0);
    nb = 0; guard = 0;
    while (busy_o === 1'b1 && guard < 20) begin
      nb++; guard++;
      set_lookup(32'h3000);
      cycle();
    end
    check("flush_len", nb, 8);
    check("flush_count", count_o, 0);
    set_lookup(32'h3000); cycle();
    check("flush_miss", lookup_hit_o, 0);

    // Flush beats a same-cycle write; re-flush mid-FLUSH ignored
    set_req(0, 32'h10, 32'h20); cycle();
    flush_i = 1'b1; set_req(0, 32'h40, 32'h50); cycle();
    check("flush_pri_ready", last_grant, 2'b00);
    nb = 0; guard = 0;
    while (busy_o === 1'b1 && guard < 20) begin
      nb++; guard++;
      if (nb == 3) flush_i = 1'b1;
      cycle();
    end
    check("reflush_len", nb, 8);
    check("reflush_count", count_o, 0);

    // Reset aborts a flush
    set_req(1, 32'h60, 32'h70); cycle();
    flush_i = 1'b1; cycle();
    cycle(); cycle();
    rst_i = 1'b1; set_lookup(32'h60); cycle();
    check("abort_busy", busy_o, 0);
    check("abort_lv", lookup_valid_o, 0);
    set_req(0, 32'h60, 32'h70); cycle();
    check("abort_ready", last_grant, 2'b01);
    set_lookup(32'h65); cycle();
    check("abort_hit", lookup_hit_o, 1);

    // Random traffic against the model
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 99) < 2) rst_i = 1'b1;
      if ($urandom_range(0, 99) < 4) flush_i = 1'b1;
      if ($urandom_range(0, 1) == 1) set_req(0, $urandom_range(0, 255), $urandom_range(0, 255));
      if ($urandom_range(0, 1) == 1) set_req(1, $urandom_range(0, 255), $urandom_range(0, 255));
      if ($urandom_range(0, 1) == 1) set_lookup($urandom_range(0, 255));
      en_crash_i = ($urandom_range(0, 3) == 0);
      cycle();
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
